// File: rtl/clk_gate_sequencer_if.sv
// ---------------------------------------------------------------------------
// clk_gate_sequencer_if
// Bundles the lock/enable controls and the clock/debug outputs of the
// clock-gate sequencer. clk_in1 and rst_n are kept as plain module ports.
//
//   locked     master -> slave   MMCM lock status (asynchronous)
//   ce_user    master -> slave   user clock-enable for clk_gated
//   clk_bufg   slave  -> master  ungated global copy of clk_in1
//   clk_bufh   slave  -> master  ungated regional copy of clk_in1
//   clk_gated  slave  -> master  glitch-free gated copy of clk_in1
//   gate_open  slave  -> master  current gate enable (negedge latch)
//   clk_div    slave  -> master  gated divide-by-DIV_N clock
//   div_tick   slave  -> master  one-cycle pulse at start of each period
//   seq_state  slave  -> master  lock sequencer contents (debug)
// ---------------------------------------------------------------------------
interface clk_gate_sequencer_if #(
    parameter int SEQ_DEPTH = 8
);
    logic                 locked;
    logic                 ce_user;
    logic                 clk_bufg;
    logic                 clk_bufh;
    logic                 clk_gated;
    logic                 gate_open;
    logic                 clk_div;
    logic                 div_tick;
    logic [SEQ_DEPTH-1:0] seq_state;

    modport master (
        output locked,
        output ce_user,
        input  clk_bufg,
        input  clk_bufh,
        input  clk_gated,
        input  gate_open,
        input  clk_div,
        input  div_tick,
        input  seq_state
    );

    modport slave (
        input  locked,
        input  ce_user,
        output clk_bufg,
        output clk_bufh,
        output clk_gated,
        output gate_open,
        output clk_div,
        output div_tick,
        output seq_state
    );
endinterface

// File: rtl/clk_gate_sequencer.sv
// ---------------------------------------------------------------------------
// clk_gate_sequencer
// Behavioural clock-buffer / clock-gating block for the A/V clock manager.
// From one MMCM output clock it provides ungated global and regional copies,
// a glitch-free gated copy that stays closed until lock has been stable for
// SEQ_DEPTH cycles, and a divide-by-DIV_N clock with a start-of-period tick.
//
// Ports:
//   clk_in1  in   source clock, all sequential logic runs on it
//   rst_n    in   asynchronous active-low reset
//   bus      slave modport of clk_gate_sequencer_if (see that file)
//
// Parameters:
//   SEQ_DEPTH  lock sequencer length, >= 2; must match the interface
//   DIV_N      divide ratio of clk_div, >= 2
// ---------------------------------------------------------------------------
module clk_gate_sequencer #(
    parameter int SEQ_DEPTH = 8,
    parameter int DIV_N     = 10
) (
    input  logic                   clk_in1,
    input  logic                   rst_n,
    clk_gate_sequencer_if.slave    bus
);

    localparam int CW = (DIV_N > 2) ? $clog2(DIV_N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV_N - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(DIV_N / 2);

    logic [SEQ_DEPTH-1:0] seq;
    logic                 ready;
    logic                 en_lat;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_next;
    logic                 clk_div_q;
    logic                 div_tick_q;

    // The shift register doubles as the synchroniser for the asynchronous
    // lock input; its last stage is the "lock has been stable" indication.
    always_ff @(posedge clk_in1 or negedge rst_n) begin
        if (!rst_n) begin
            seq <= '0;
        end else begin
            seq <= {seq[SEQ_DEPTH-2:0], bus.locked};
        end
    end

    assign ready = seq[SEQ_DEPTH-1];

    // Enable is captured on the falling edge so it only ever changes while
    // clk_in1 is low; the AND gate below therefore cannot emit a runt pulse.
    always_ff @(negedge clk_in1 or negedge rst_n) begin
        if (!rst_n) begin
            en_lat <= 1'b0;
        end else begin
            en_lat <= ready & bus.ce_user;
        end
    end

    always_comb begin
        cnt_next = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
    end

    // Divider is held cleared while not ready, so the first period after
    // lock is one cycle short (cnt resumes at 1); later periods are DIV_N.
    always_ff @(posedge clk_in1 or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            clk_div_q  <= 1'b0;
            div_tick_q <= 1'b0;
        end else if (!ready) begin
            cnt        <= '0;
            clk_div_q  <= 1'b0;
            div_tick_q <= 1'b0;
        end else begin
            cnt        <= cnt_next;
            clk_div_q  <= (cnt_next >= CNT_HALF);
            div_tick_q <= (cnt_next == '0);
        end
    end

    assign bus.clk_bufg  = clk_in1;
    assign bus.clk_bufh  = clk_in1;
    assign bus.clk_gated = clk_in1 & en_lat;
    assign bus.gate_open = en_lat;
    assign bus.clk_div   = clk_div_q;
    assign bus.div_tick  = div_tick_q;
    assign bus.seq_state = seq;

endmodule

// File: tb/tb_clk_gate_sequencer.sv
`timescale 1ns/1ps
module tb_clk_gate_sequencer;

    localparam int SEQ_DEPTH = 8;
    localparam int DIV_N     = 10;

    logic clk_in1 = 1'b0;
    logic rst_n   = 1'b0;

    clk_gate_sequencer_if #(.SEQ_DEPTH(SEQ_DEPTH)) bus ();

    clk_gate_sequencer #(.SEQ_DEPTH(SEQ_DEPTH), .DIV_N(DIV_N)) dut (
        .clk_in1 (clk_in1),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    initial forever #5 clk_in1 = ~clk_in1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: lock history as a list of past samples, divider as
    // "number of consecutive ready cycles" reduced modulo DIV_N.
    bit m_hist [SEQ_DEPTH];
    int m_run;
    bit m_en;

    function automatic void model_reset();
        foreach (m_hist[i]) m_hist[i] = 1'b0;
        m_run = 0;
        m_en  = 1'b0;
    endfunction

    function automatic void model_pos(input bit lk);
        if (m_hist[SEQ_DEPTH-1]) m_run++;
        else m_run = 0;
        for (int i = SEQ_DEPTH - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = lk;
    endfunction

    function automatic void model_neg(input bit ce);
        m_en = m_hist[SEQ_DEPTH-1] && ce;
    endfunction

    function automatic logic [SEQ_DEPTH-1:0] exp_seq();
        logic [SEQ_DEPTH-1:0] v;
        for (int i = 0; i < SEQ_DEPTH; i++) v[i] = m_hist[i];
        return v;
    endfunction

    function automatic bit exp_div();
        return (m_run > 0) && ((m_run % DIV_N) >= (DIV_N / 2));
    endfunction

    function automatic bit exp_tick();
        return (m_run > 0) && ((m_run % DIV_N) == 0);
    endfunction

    // clk_gated must only rise with clk_in1 rising and fall with it falling.
    bit mon_en = 1'b0;
    int rises  = 0;
    always @(posedge bus.clk_gated) if (mon_en) begin
        rises++;
        chk("gated_rise_phase", 32'($time % 10), 32'd5);
    end
    always @(negedge bus.clk_gated) if (mon_en) begin
        chk("gated_fall_phase", 32'($time % 10), 32'd0);
    end

    // One clock cycle, entered and left at negedge+1.
    task automatic cycle(input bit lk, input bit ce, input bit ce_late,
                         output logic [SEQ_DEPTH-1:0] o_seq, output logic o_div,
                         output logic o_tick, output logic o_gated, output logic o_gate);
        #2;
        bus.locked = lk;
        if (!ce_late) bus.ce_user = ce;
        @(posedge clk_in1);
        model_pos(lk);
        #1;
        o_seq   = bus.seq_state;
        o_div   = bus.clk_div;
        o_tick  = bus.div_tick;
        o_gated = bus.clk_gated;
        chk("seq_state", 32'(o_seq), 32'(exp_seq()));
        chk("clk_div", 32'(o_div), 32'(exp_div()));
        chk("div_tick", 32'(o_tick), 32'(exp_tick()));
        chk("clk_gated_high", 32'(o_gated), 32'(m_en));
        #2;
        if (ce_late) bus.ce_user = ce;
        @(negedge clk_in1);
        model_neg(ce);
        #1;
        o_gate = bus.gate_open;
        chk("gate_open", 32'(o_gate), 32'(m_en));
        chk("clk_gated_low", 32'(bus.clk_gated), 32'd0);
    endtask

    typedef struct {
        bit       lk;
        bit       ce;
        bit [7:0] seq;
        bit       gated;
        bit       gate;
        bit       div;
        bit       tick;
    } vec_t;

    vec_t tbl [19];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [SEQ_DEPTH-1:0] s_seq;
        logic s_div, s_tick, s_gated, s_gate;
        int drop;

        // Lock fill from locked first sampled high at posedge k (row j = k+j).
        tbl[0]  = '{1, 1, 8'h01, 0, 0, 0, 0};
        tbl[1]  = '{1, 1, 8'h03, 0, 0, 0, 0};
        tbl[2]  = '{1, 1, 8'h07, 0, 0, 0, 0};
        tbl[3]  = '{1, 1, 8'h0F, 0, 0, 0, 0};
        tbl[4]  = '{1, 1, 8'h1F, 0, 0, 0, 0};
        tbl[5]  = '{1, 1, 8'h3F, 0, 0, 0, 0};
        tbl[6]  = '{1, 1, 8'h7F, 0, 0, 0, 0};
        tbl[7]  = '{1, 1, 8'hFF, 0, 1, 0, 0};
        tbl[8]  = '{1, 1, 8'hFF, 1, 1, 0, 0};
        tbl[9]  = '{1, 1, 8'hFF, 1, 1, 0, 0};
        tbl[10] = '{1, 1, 8'hFF, 1, 1, 0, 0};
        tbl[11] = '{1, 1, 8'hFF, 1, 1, 0, 0};
        tbl[12] = '{1, 1, 8'hFF, 1, 1, 1, 0};
        tbl[13] = '{1, 1, 8'hFF, 1, 1, 1, 0};
        tbl[14] = '{1, 1, 8'hFF, 1, 1, 1, 0};
        tbl[15] = '{1, 1, 8'hFF, 1, 1, 1, 0};
        tbl[16] = '{1, 1, 8'hFF, 1, 1, 1, 0};
        tbl[17] = '{1, 1, 8'hFF, 1, 1, 0, 1};
        tbl[18] = '{1, 1, 8'hFF, 1, 1, 0, 0};

        // Reset with lock and enable both asserted.
        bus.locked  = 1'b1;
        bus.ce_user = 1'b1;
        model_reset();
        #2;
        chk("rst_seq_state", 32'(bus.seq_state), 32'd0);
        chk("rst_clk_gated", 32'(bus.clk_gated), 32'd0);
        chk("rst_clk_div", 32'(bus.clk_div), 32'd0);
        chk("rst_div_tick", 32'(bus.div_tick), 32'd0);
        chk("rst_gate_open", 32'(bus.gate_open), 32'd0);
        chk("rst_bufg_low", 32'(bus.clk_bufg), 32'(clk_in1));
        #5;
        chk("rst_bufg_high", 32'(bus.clk_bufg), 32'(clk_in1));
        chk("rst_bufh_high", 32'(bus.clk_bufh), 32'(clk_in1));
        chk("rst_clk_gated_hi", 32'(bus.clk_gated), 32'd0);
        #4;
        bus.locked = 1'b0;
        rst_n = 1'b1;
        @(negedge clk_in1);
        #1;
        mon_en = 1'b1;

        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 1'b0, s_seq, s_div, s_tick, s_gated, s_gate);
        chk("no_gate_unlocked", 32'(rises), 32'd0);

        for (int j = 0; j < 19; j++) begin
            cycle(tbl[j].lk, tbl[j].ce, 1'b0, s_seq, s_div, s_tick, s_gated, s_gate);
            chk($sformatf("tbl%0d_seq", j), 32'(s_seq), 32'(tbl[j].seq));
            chk($sformatf("tbl%0d_gated", j), 32'(s_gated), 32'(tbl[j].gated));
            chk($sformatf("tbl%0d_gate", j), 32'(s_gate), 32'(tbl[j].gate));
            chk($sformatf("tbl%0d_div", j), 32'(s_div), 32'(tbl[j].div));
            chk($sformatf("tbl%0d_tick", j), 32'(s_tick), 32'(tbl[j].tick));
            if (j == 7) chk("early_gated_edges", 32'(rises), 32'd0);
        end

        // Random enable toggling (both half-phases) and occasional lock drops.
        drop = 0;
        for (int i = 0; i < 250; i++) begin
            bit lk;
            if (drop > 0) begin
                lk = 1'b0;
                drop--;
            end else if ($urandom_range(0, 24) == 0) begin
                lk = 1'b0;
                drop = $urandom_range(0, 11);
            end else begin
                lk = 1'b1;
            end
            cycle(lk, ($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)),
                  s_seq, s_div, s_tick, s_gated, s_gate);
        end

        // Lock loss from steady state: locked first sampled low at posedge m.
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, 1'b0, s_seq, s_div, s_tick, s_gated, s_gate);
        for (int j = 0; j < 10; j++) begin
            cycle(1'b0, 1'b1, 1'b0, s_seq, s_div, s_tick, s_gated, s_gate);
            if (j == 0) chk("loss_seq_m", 32'(s_seq), 32'h0FE);
            if (j == 6) chk("loss_gate_m6", 32'(s_gate), 32'd1);
            if (j == 7) chk("loss_seq_m7", 32'(s_seq), 32'd0);
            if (j == 7) chk("loss_gate_m7", 32'(s_gate), 32'd0);
            if (j == 8) chk("loss_gated_m8", 32'(s_gated), 32'd0);
            if (j == 8) chk("loss_div_m8", 32'(s_div), 32'd0);
        end
        cycle(1'b1, 1'b1, 1'b0, s_seq, s_div, s_tick, s_gated, s_gate);
        chk("relock_seq", 32'(s_seq), 32'h001);
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 1'b0, s_seq, s_div, s_tick, s_gated, s_gate);

        // Asynchronous reset in the middle of a high phase.
        @(posedge clk_in1);
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("arst_seq_state", 32'(bus.seq_state), 32'd0);
        chk("arst_gate_open", 32'(bus.gate_open), 32'd0);
        chk("arst_clk_gated", 32'(bus.clk_gated), 32'd0);
        chk("arst_clk_div", 32'(bus.clk_div), 32'd0);
        chk("arst_div_tick", 32'(bus.div_tick), 32'd0);
        chk("arst_bufg", 32'(bus.clk_bufg), 32'(clk_in1));
        @(negedge clk_in1);
        #1;
        model_reset();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        cycle(1'b1, 1'b1, 1'b0, s_seq, s_div, s_tick, s_gated, s_gate);
        chk("post_rst_seq", 32'(s_seq), 32'h001);
        for (int i = 0; i < 24; i++) cycle(1'b1, 1'b1, 1'b0, s_seq, s_div, s_tick, s_gated, s_gate);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
